// File: rtl/fd_fp_pkg.sv
// Shared constants for the binary32 adder datapath: packed-field positions,
// internal significand layout and the direction-bit index of the shift and
// exponent-adjust controls.
package fd_fp_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int FRAC_HI  = 22;
  localparam int FRAC_LO  = 0;

  localparam int SIG_W    = 27;
  localparam int CARRY    = 26;
  localparam int HIDDEN   = 25;

  localparam int DIR_BIT  = 8;

  // Expand a packed operand into the internal significand {0, hidden, frac, guard, sticky}.
  function automatic logic [SIG_W-1:0] unpack_sig(input logic [31:0] op);
    return {1'b0, |op[EXP_HI:EXP_LO], op[FRAC_HI:FRAC_LO], 2'b00};
  endfunction

endpackage

// File: rtl/fd_shifter.sv
// 27-bit bidirectional barrel shifter. Left shifts fill with zeros; right
// shifts fold every bit that falls off the bottom into bit 0 (sticky).
module fd_shifter import fd_fp_pkg::*; (
  input  logic [SIG_W-1:0] data,
  input  logic [7:0]       amount,
  input  logic             left,
  output logic [SIG_W-1:0] result
);

  logic [2*SIG_W-1:0] ext;
  logic               sticky;

  // Shift via a double-width window so the discarded bits stay visible for sticky.
  always_comb begin
    ext    = {data, {SIG_W{1'b0}}} >> amount;
    sticky = (amount >= 8'(SIG_W)) ? |data : |ext[SIG_W-1:0];
    if (left)
      result = data << amount;
    else
      result = ext[2*SIG_W-1:SIG_W] | {{(SIG_W-1){1'b0}}, sticky};
  end

endmodule

// File: rtl/fd_fp_adder.sv
// Binary32 floating-point adder datapath. All decisions come from an external
// controller through the sinal* inputs; two register stages (ALU result, then
// normalised result) produce the packed sum on resultado.
module fd_fp_adder import fd_fp_pkg::*; (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      operando_a,
  input  logic [31:0]      operando_b,
  input  logic             sinalMuxFP1,
  input  logic             sinalMuxFP2,
  input  logic             sinalMuxFP3,
  input  logic             sinalMuxFP4,
  input  logic             sinalMuxFP5,
  input  logic [7:0]       sinalShiftFract,
  input  logic [8:0]       sinalShiftRes,
  input  logic [8:0]       sinalIncOrDec,
  input  logic             sinalRound,
  output logic [7:0]       exp_dif,
  output logic [SIG_W-1:0] ula,
  output logic [SIG_W-1:0] round_fract,
  output logic [31:0]      resultado
);

  // Round-to-nearest-even on bit 3; a carry out of bit 26 saturates to 1<<26
  // so the controller can renormalise with one extra pass.
  function automatic logic [SIG_W-1:0] round_rne(input logic [SIG_W-1:0] s, input logic en);
    logic                inc;
    logic [SIG_W-3:0]    t;
    if (!en) return s;
    inc = s[2] & ((s[1:0] != 2'b00) | s[3]);
    t   = {1'b0, s[SIG_W-1:3]} + {{(SIG_W-3){1'b0}}, inc};
    if (t[SIG_W-3]) return {1'b1, {(SIG_W-1){1'b0}}};
    return {t[SIG_W-4:0], 3'b000};
  endfunction

  logic [7:0]       exp_a, exp_b, big_exp;
  logic             sign_a, sign_b, sign_x;
  logic [SIG_W-1:0] sig_a, sig_b, align_in, aligned;
  logic [SIG_W-1:0] path_a, path_b, alu_x, alu_y, alu;

  logic [SIG_W-1:0] ula_p1;
  logic [7:0]       exp_p1;
  logic             sign_p1;

  logic [SIG_W-1:0] norm_in, norm_out;
  logic [7:0]       exp_base, exp_next;

  logic [SIG_W-1:0] sig_p2;
  logic [7:0]       exp_p2;
  logic             sign_p2;

  assign exp_a   = operando_a[EXP_HI:EXP_LO];
  assign exp_b   = operando_b[EXP_HI:EXP_LO];
  assign sign_a  = operando_a[SIGN_BIT];
  assign sign_b  = operando_b[SIGN_BIT];
  assign sig_a   = unpack_sig(operando_a);
  assign sig_b   = unpack_sig(operando_b);
  assign exp_dif = exp_a - exp_b;

  assign align_in = sinalMuxFP1 ? sig_a : sig_b;

  fd_shifter u_align (
    .data   (align_in),
    .amount (sinalShiftFract),
    .left   (1'b0),
    .result (aligned)
  );

  assign path_a  = sinalMuxFP1 ? aligned : sig_a;
  assign path_b  = sinalMuxFP1 ? sig_b   : aligned;
  assign big_exp = sinalMuxFP1 ? exp_b   : exp_a;
  assign alu_x   = sinalMuxFP2 ? path_b  : path_a;
  assign alu_y   = sinalMuxFP3 ? path_b  : path_a;
  assign sign_x  = sinalMuxFP2 ? sign_b  : sign_a;
  assign alu     = (sign_a == sign_b) ? alu_x + alu_y : alu_x - alu_y;

  // Stage A: ALU result, exponent biased up one for the bit-26 target, sign.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ula_p1  <= '0;
      exp_p1  <= '0;
      sign_p1 <= 1'b0;
    end else begin
      ula_p1  <= alu;
      exp_p1  <= big_exp + 8'd1;
      sign_p1 <= sign_x;
    end
  end

  assign ula         = ula_p1;
  assign round_fract = round_rne(sig_p2, sinalRound);
  assign norm_in     = sinalMuxFP4 ? round_fract : ula_p1;

  fd_shifter u_norm (
    .data   (norm_in),
    .amount (sinalShiftRes[7:0]),
    .left   (sinalShiftRes[DIR_BIT]),
    .result (norm_out)
  );

  assign exp_base = sinalMuxFP5 ? exp_p2 : exp_p1;
  assign exp_next = sinalIncOrDec[DIR_BIT] ? exp_base - sinalIncOrDec[7:0]
                                           : exp_base + sinalIncOrDec[7:0];

  // Stage B: normalised significand, adjusted exponent and sign.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sig_p2  <= '0;
      exp_p2  <= '0;
      sign_p2 <= 1'b0;
    end else begin
      sig_p2  <= norm_out;
      exp_p2  <= exp_next;
      sign_p2 <= sign_p1;
    end
  end

  assign resultado = (sig_p2 == '0) ? 32'h0000_0000
                                    : {sign_p2, exp_p2, round_fract[CARRY-1:3]};

endmodule

// File: tb/tb_fd_fp_adder.sv
// Directed bench for fd_fp_adder: hand-computed sums, rounding, renormalisation,
// cancellation and asynchronous reset behaviour.
module tb_fd_fp_adder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] operando_a, operando_b;
  logic        sinalMuxFP1, sinalMuxFP2, sinalMuxFP3, sinalMuxFP4, sinalMuxFP5;
  logic [7:0]  sinalShiftFract;
  logic [8:0]  sinalShiftRes, sinalIncOrDec;
  logic        sinalRound;
  logic [7:0]  exp_dif;
  logic [26:0] ula, round_fract;
  logic [31:0] resultado;

  int tests  = 0;
  int failed = 0;

  fd_fp_adder dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .operando_a      (operando_a),
    .operando_b      (operando_b),
    .sinalMuxFP1     (sinalMuxFP1),
    .sinalMuxFP2     (sinalMuxFP2),
    .sinalMuxFP3     (sinalMuxFP3),
    .sinalMuxFP4     (sinalMuxFP4),
    .sinalMuxFP5     (sinalMuxFP5),
    .sinalShiftFract (sinalShiftFract),
    .sinalShiftRes   (sinalShiftRes),
    .sinalIncOrDec   (sinalIncOrDec),
    .sinalRound      (sinalRound),
    .exp_dif         (exp_dif),
    .ula             (ula),
    .round_fract     (round_fract),
    .resultado       (resultado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    operando_a = a;
    operando_b = b;
  endtask

  task automatic set_ctl(input logic fp1, input logic fp2, input logic fp3,
                         input logic fp4, input logic fp5, input logic [7:0] sf,
                         input logic [8:0] sr, input logic [8:0] id, input logic rnd);
    sinalMuxFP1     = fp1;
    sinalMuxFP2     = fp2;
    sinalMuxFP3     = fp3;
    sinalMuxFP4     = fp4;
    sinalMuxFP5     = fp5;
    sinalShiftFract = sf;
    sinalShiftRes   = sr;
    sinalIncOrDec   = id;
    sinalRound      = rnd;
  endtask

  initial begin
    reset_n = 1'b0;
    set_ops(32'h0, 32'h0);
    set_ctl(0, 0, 0, 0, 0, 8'd0, 9'h000, 9'h000, 0);
    #1;
    check("reset_ula", ula, 32'h0);
    check("reset_res", resultado, 32'h0);
    check("reset_round", round_fract, 32'h0);
    tick(1);
    reset_n = 1'b1;

    // 1.5 + 0.5 = 2.0
    set_ops(32'h3FC00000, 32'h3F000000);
    set_ctl(0, 0, 1, 0, 0, 8'd1, 9'h100, 9'h000, 0);
    #1;
    check("t1_expdif", exp_dif, 32'h01);
    tick(2);
    check("t1_ula", ula, 32'h4000000);
    check("t1_res", resultado, 32'h40000000);

    // 1.268 + 2.456
    set_ops(32'h3FA24DD3, 32'h401D2F1B);
    set_ctl(1, 1, 0, 0, 0, 8'd1, 9'h101, 9'h101, 0);
    #1;
    check("t2_expdif", exp_dif, 32'hFF);
    tick(2);
    check("t2_ula", ula, 32'h3B95812);
    check("t2_res", resultado, 32'h406E5604);

    // -1.268 + 2.456
    set_ops(32'hBFA24DD3, 32'h401D2F1B);
    set_ctl(1, 1, 0, 0, 0, 8'd1, 9'h102, 9'h102, 0);
    tick(2);
    check("t3_ula", ula, 32'h13020C6);
    check("t3_res", resultado, 32'h3F981063);

    // Tie with odd bit 3: round-to-nearest-even increments
    set_ops(32'h3F800003, 32'h3F800000);
    set_ctl(0, 0, 1, 0, 0, 8'd0, 9'h100, 9'h000, 1);
    tick(2);
    check("rnd_on_fract", round_fract, 32'h4000010);
    check("rnd_on_res", resultado, 32'h40000002);
    sinalRound = 1'b0;
    #1;
    check("rnd_off_fract", round_fract, 32'h400000C);
    check("rnd_off_res", resultado, 32'h40000001);

    // Alignment sticky turns an apparent tie into round-up: 1.875 + B(exp 124, frac 9)
    set_ops(32'h3FF00000, 32'h3E000009);
    set_ctl(0, 0, 1, 0, 0, 8'd3, 9'h100, 9'h000, 1);
    tick(2);
    check("sticky_ula", ula, 32'h4000005);
    check("sticky_res", resultado, 32'h40000001);

    // Right normalisation shift with exponent increment
    set_ops(32'h3FC00000, 32'h3F000000);
    set_ctl(0, 0, 1, 0, 0, 8'd1, 9'h001, 9'h001, 0);
    tick(2);
    check("rshift_res", resultado, 32'h40C00000);

    // Rounding carry out of bit 26, then one renormalisation pass
    set_ops(32'h3FFFFFFF, 32'h33800000);
    set_ctl(0, 0, 1, 0, 0, 8'd24, 9'h101, 9'h101, 1);
    tick(2);
    check("carry_ula", ula, 32'h3FFFFFE);
    check("carry_fract", round_fract, 32'h4000000);
    check("carry_res_pre", resultado, 32'h3F800000);
    set_ctl(0, 0, 1, 1, 1, 8'd24, 9'h100, 9'h001, 1);
    tick(1);
    check("carry_res_post", resultado, 32'h40000000);
    set_ctl(0, 0, 1, 0, 0, 8'd24, 9'h101, 9'h101, 1);

    // Cancellation: 1.0 + (-1.0)
    set_ops(32'h3F800000, 32'hBF800000);
    set_ctl(0, 0, 1, 0, 0, 8'd0, 9'h100, 9'h000, 0);
    tick(2);
    check("cancel_ula", ula, 32'h0);
    check("cancel_res", resultado, 32'h0);

    // Asynchronous reset in mid-cycle, then recovery
    set_ops(32'h3FC00000, 32'h3F000000);
    set_ctl(0, 0, 1, 0, 0, 8'd1, 9'h100, 9'h000, 0);
    tick(2);
    check("pre_reset_res", resultado, 32'h40000000);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_reset_ula", ula, 32'h0);
    check("mid_reset_res", resultado, 32'h0);
    check("mid_reset_round", round_fract, 32'h0);
    check("mid_reset_expdif", exp_dif, 32'h01);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    check("post_reset_ula", ula, 32'h4000000);
    check("post_reset_res_e1", resultado, 32'h0);
    tick(1);
    check("post_reset_res_e2", resultado, 32'h40000000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
